// File: rtl/gpio_link_master.sv
// Host-side sequencer for the PULPino GPIO byte-handshake link: resets the core,
// sends a start/end byte pair, then collects the streamed range into a show-ahead FIFO.
module gpio_link_master #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DUT_RST_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_start,
  input  logic [7:0]  cmd_end,
  input  logic        abort,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        dut_rst_n,
  output logic [31:0] gpio_to_dut,
  input  logic [31:0] gpio_from_dut
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > DUT_RST_CYCLES) ? TIMEOUT_CYCLES : DUT_RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DRST, S_TX_REQ, S_TX_REL, S_RX_WAIT, S_RX_ACK, S_RX_REL, S_DONE, S_ERR
  } state_t;

  state_t                      state, state_n;
  logic [7:0]                  start_q, end_q, rem_q;
  logic                        idx_q;
  logic [CW-1:0]               cnt_q;
  logic                        cnt_en, tmo, accept, push, pop, flush, full, empty;
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic                        ack_s, stb_s;
  logic [FIFO_DEPTH-1:0][7:0]  mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        unused_hi;

  assign unused_hi = ^gpio_from_dut[31:10];

  // Only the strobe/ack pair is synchronised; data is qualified by the synced strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else begin
      sync_q[0] <= gpio_from_dut[9:8];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign {stb_s, ack_s} = sync_q[SYNC_STAGES-1];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = rx_ready && !empty;
  assign flush = !rst_n || (abort && state != S_IDLE);
  assign tmo   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    cnt_en  = 1'b0;
    accept  = 1'b0;
    push    = 1'b0;
    unique case (state)
      S_IDLE:    if (cmd_valid && !abort) begin state_n = S_DRST; accept = 1'b1; end
      S_DRST:    if (cnt_q == CW'(DUT_RST_CYCLES - 1)) state_n = S_TX_REQ; else cnt_en = 1'b1;
      S_TX_REQ:  if (ack_s) state_n = S_TX_REL; else if (tmo) state_n = S_ERR; else cnt_en = 1'b1;
      S_TX_REL:
        if (!ack_s)   state_n = !idx_q ? S_TX_REQ : (rem_q != 8'd0) ? S_RX_WAIT : S_DONE;
        else if (tmo) state_n = S_ERR;
        else          cnt_en = 1'b1;
      // A full FIFO is host backpressure, so the timeout is frozen while stalled.
      S_RX_WAIT:
        if (!full) begin
          if (stb_s)    begin push = 1'b1; state_n = S_RX_ACK; end
          else if (tmo) state_n = S_ERR;
          else          cnt_en = 1'b1;
        end
      S_RX_ACK:  if (!stb_s) state_n = S_RX_REL; else if (tmo) state_n = S_ERR; else cnt_en = 1'b1;
      S_RX_REL:  state_n = (rem_q == 8'd0) ? S_DONE : S_RX_WAIT;
      S_DONE:    state_n = S_IDLE;
      S_ERR:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      rem_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt_q <= (state_n != state) ? '0 : cnt_en ? cnt_q + 1'b1 : cnt_q;
      if (accept) begin
        start_q     <= cmd_start;
        end_q       <= cmd_end;
        rem_q       <= (cmd_end > cmd_start) ? cmd_end - cmd_start : 8'd0;
        idx_q       <= 1'b0;
        timeout_err <= 1'b0;
      end else if (state_n == S_ERR) begin
        timeout_err <= 1'b1;
      end
      if (state == S_TX_REL && state_n == S_TX_REQ) idx_q <= 1'b1;
      if (state == S_RX_ACK && state_n == S_RX_REL) rem_q <= rem_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= gpio_from_dut[7:0];
  end

  assign rx_data   = mem[rd_ptr[AW-1:0]];
  assign rx_valid  = !empty;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dut_rst_n = !(state == S_DRST || state == S_ERR);

  // Host-side pins are a pure decode of state and latched bytes.
  always_comb begin
    gpio_to_dut = '0;
    unique case (state)
      S_TX_REQ: gpio_to_dut[9:0] = {2'b10, idx_q ? end_q : start_q};
      S_TX_REL: gpio_to_dut[9:0] = {2'b00, idx_q ? end_q : start_q};
      S_RX_ACK: gpio_to_dut[8]   = 1'b1;
      default:  gpio_to_dut      = '0;
    endcase
  end
endmodule

// File: tb/tb_gpio_link_master.sv
// Bench for gpio_link_master: a behavioural core model answers the link, and a
// queue of expected bytes (start..end-1 per command) is compared with what the host pops.
module tb_gpio_link_master;
  localparam int FD = 4, SS = 2, TO = 64, DR = 8;

  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, abort = 0, rx_ready = 0;
  logic [7:0]  cmd_start = 0, cmd_end = 0;
  logic        cmd_ready, rx_valid, busy, done, timeout_err, dut_rst_n;
  logic [7:0]  rx_data;
  logic [31:0] gpio_to_dut, gpio_from_dut;

  gpio_link_master #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .DUT_RST_CYCLES(DR)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err), .dut_rst_n(dut_rst_n),
    .gpio_to_dut(gpio_to_dut), .gpio_from_dut(gpio_from_dut));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, done_cnt = 0;
  bit rxv_seen = 0, core_hold = 0;
  logic [7:0] got_q[$], exp_q[$];

  // Core firmware model: take start and end bytes, then stream start..end-1.
  typedef enum {C_W0, C_W0R, C_W1, C_W1R, C_TX, C_TXA, C_TXR, C_IDLE} core_t;
  core_t cst = C_W0;
  logic [7:0] c_s = 0, c_e = 0, c_cur = 0;
  logic [9:0] core_out = 0;
  int c_dly = 0;
  assign gpio_from_dut = {22'h0, core_out};

  always @(posedge clk) begin
    if (!dut_rst_n || core_hold) begin
      cst <= C_W0; core_out <= '0; c_dly <= 0;
    end else case (cst)
      C_W0:  if (gpio_to_dut[9]) begin c_s <= gpio_to_dut[7:0]; core_out[8] <= 1'b1; cst <= C_W0R; end
      C_W0R: if (!gpio_to_dut[9]) begin core_out[8] <= 1'b0; cst <= C_W1; end
      C_W1:  if (gpio_to_dut[9]) begin c_e <= gpio_to_dut[7:0]; core_out[8] <= 1'b1; cst <= C_W1R; end
      C_W1R: if (!gpio_to_dut[9]) begin
        core_out[8] <= 1'b0; c_cur <= c_s; c_dly <= $urandom_range(0, 3);
        cst <= (c_e > c_s) ? C_TX : C_IDLE;
      end
      C_TX:  if (c_dly > 0) c_dly <= c_dly - 1;
             else begin core_out <= {2'b10, c_cur}; cst <= C_TXA; end
      C_TXA: if (gpio_to_dut[8]) begin core_out[9] <= 1'b0; cst <= C_TXR; end
      C_TXR: if (!gpio_to_dut[8]) begin
        c_dly <= $urandom_range(0, 3); c_cur <= c_cur + 8'd1;
        cst <= (c_cur + 8'd1 == c_e) ? C_IDLE : C_TX;
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) rxv_seen = 1;
    if (done) done_cnt++;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_cmd(input logic [7:0] s, input logic [7:0] e);
    for (int i = 0; i < 200 && !cmd_ready; i++) tick();
    cmd_start = s; cmd_end = e; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    for (int b = s; b < int'(e); b++) exp_q.push_back(8'(b));
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (rnd) rx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic drain();
    rx_ready = 1;
    repeat (FD + 4) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; repeat (2) tick();
    tests++; if (gpio_to_dut !== 32'h0) begin fails++; $display("FAIL reset_gpio: got %h expected 0", gpio_to_dut); end
    tests++; if (dut_rst_n !== 1'b1) begin fails++; $display("FAIL reset_dut_rst_n: got %b expected 1", dut_rst_n); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    rst_n = 1; tick();
  endtask

  task automatic test_normal();
    int d0 = done_cnt;
    rx_ready = 1;
    send_cmd(8'h10, 8'h14);
    run_until_done(2000, 0);
    drain();
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL normal_done: got %0d pulses expected 1", done_cnt - d0); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL normal_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL normal_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (gpio_to_dut !== 32'h0 || busy !== 1'b0) begin fails++; $display("FAIL normal_idle: got gpio %h busy %b expected 0 0", gpio_to_dut, busy); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_empty();
    int d0 = done_cnt;
    rxv_seen = 0; rx_ready = 1;
    send_cmd(8'h20, 8'h20); run_until_done(1000, 0);
    send_cmd(8'h30, 8'h05); run_until_done(1000, 0);
    repeat (10) tick();
    tests++; if (done_cnt != d0 + 2) begin fails++; $display("FAIL empty_done: got %0d pulses expected 2", done_cnt - d0); end
    tests++; if (rxv_seen !== 1'b0 || got_q.size() != 0) begin fails++; $display("FAIL empty_rx: got %0d bytes expected 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    rx_ready = 0;
    send_cmd(8'h00, 8'h0A);
    repeat (200) tick();
    tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp_stall: got err %b busy %b expected 0 1", timeout_err, busy); end
    tests++; if (rx_valid !== 1'b1 || got_q.size() != 0) begin fails++; $display("FAIL bp_hold: got rx_valid %b popped %0d expected 1 0", rx_valid, got_q.size()); end
    rx_ready = 1;
    run_until_done(2000, 0);
    drain();
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt - d0); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int d0 = done_cnt;
      logic [7:0] s, e;
      int r;
      s = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r == 0) e = (s == 0) ? 8'd0 : s - 8'($urandom_range(1, s));
      else e = (int'(s) + r > 255) ? 8'hFF : s + 8'(r);
      send_cmd(s, e);
      run_until_done(3000, 1);
      drain();
      tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL rand%0d_done: got %0d pulses expected 1", n, done_cnt - d0); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_count: got %0d expected %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_byte%0d: got %h expected %h", n, i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, n = 0;
    core_hold = 1; rx_ready = 1;
    send_cmd(8'h10, 8'h12);
    exp_q.delete();
    while (n < 400 && !timeout_err) begin tick(); n++; end
    tests++; if (n < DR + TO - 2 || n > DR + TO + SS + 2) begin fails++; $display("FAIL timeout_latency: got %0d cycles expected about %0d", n, DR + TO); end
    tests++; if (gpio_to_dut !== 32'h0 || dut_rst_n !== 1'b0) begin fails++; $display("FAIL timeout_err_state: got gpio %h rst_n %b expected 0 0", gpio_to_dut, dut_rst_n); end
    tick();
    tests++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_idle: got busy %b err %b expected 0 1", busy, timeout_err); end
    repeat (3) tick();
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL timeout_no_done: got %0d pulses expected 0", done_cnt - d0); end
    core_hold = 0;
    send_cmd(8'h07, 8'h09);
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
    run_until_done(2000, 0);
    drain();
    tests++; if (got_q.size() != 2 || got_q.size() != exp_q.size() || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
      begin fails++; $display("FAIL timeout_recover: got %0d bytes expected 2 (07,08)", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort_rx();
    int d0 = done_cnt;
    rx_ready = 1;
    send_cmd(8'h00, 8'hFF);
    for (int i = 0; i < 3000 && got_q.size() < 3; i++) tick();
    rx_ready = 0; abort = 1;
    tick();
    abort = 0;
    tests++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy %b rx_valid %b expected 0 0", busy, rx_valid); end
    tests++; if (gpio_to_dut !== 32'h0 || dut_rst_n !== 1'b1) begin fails++; $display("FAIL abort_pins: got gpio %h rst_n %b expected 0 1", gpio_to_dut, dut_rst_n); end
    tests++; if (got_q.size() != 3) begin fails++; $display("FAIL abort_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL abort_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    repeat (3) tick();
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
    got_q.delete(); exp_q.delete();
    rx_ready = 1;
    send_cmd(8'h01, 8'h03);
    run_until_done(2000, 0);
    drain();
    tests++; if (got_q.size() != 2 || got_q.size() != exp_q.size() || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
      begin fails++; $display("FAIL abort_next_cmd: got %0d bytes expected 2 (01,02)", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort_idle();
    cmd_start = 8'h01; cmd_end = 8'h05; cmd_valid = 1; abort = 1;
    tick();
    cmd_valid = 0; abort = 0;
    tests++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL abort_idle_accept: got busy %b ready %b expected 0 1", busy, cmd_ready); end
    repeat (4) tick();
    tests++; if (busy !== 1'b0 || dut_rst_n !== 1'b1) begin fails++; $display("FAIL abort_idle_later: got busy %b rst_n %b expected 0 1", busy, dut_rst_n); end
  endtask

  task automatic test_reset_mid_tx();
    int n = 0;
    rx_ready = 0;
    send_cmd(8'h40, 8'h43);
    run_until_done(2000, 0);
    send_cmd(8'h50, 8'h52);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL accept_no_flush: got rx_valid %b expected 1", rx_valid); end
    while (n < 200 && !gpio_to_dut[9]) begin tick(); n++; end
    rst_n = 0;
    tick();
    tests++; if (gpio_to_dut !== 32'h0 || dut_rst_n !== 1'b1) begin fails++; $display("FAIL rst_mid_pins: got gpio %h rst_n %b expected 0 1", gpio_to_dut, dut_rst_n); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got busy %b done %b ready %b expected 0 0 1", busy, done, cmd_ready); end
    tests++; if (rx_valid !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL rst_mid_fifo: got rx_valid %b err %b expected 0 0", rx_valid, timeout_err); end
    rst_n = 1; tick();
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_backpressure();
    test_random();
    test_timeout();
    test_abort_rx();
    test_abort_idle();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_link_master.md
# gpio_link_master

Host-side sequencer for the 10-bit GPIO byte-handshake link into the PULPino core (`gpio_in[9]` = host write strobe, `gpio_in[8]` = host read ack, `gpio_in[7:0]` = host data; `gpio_out[9]` = core write strobe, `gpio_out[8]` = core ack, `gpio_out[7:0]` = core data). The block sits in the CW305 top level between the host register bank and the core.

Per command, it:
- resets the core;
- sends a start byte and an end byte with 4-phase handshakes;
- collects the `end − start` bytes the core streams back into an internal FIFO for host readout.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: receive FIFO entries. Power of two, ≥2.
- `SYNC_STAGES`, 2: flop stages on `gpio_from_dut[9:8]`. Must be ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for any core handshake edge.
- `DUT_RST_CYCLES`, 8: cycles `dut_rst_n` is held low per command.

Ports:
- `clk` in 1: single clock for the block. Core also runs on `clk`.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_start` in 8: range start byte.
- `cmd_end` in 8: range end byte.
- `abort` in 1: cancels the current command.
- `rx_data` out 8: FIFO head (show-ahead).
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pop the FIFO head when `rx_valid`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `timeout_err` out 1: sticky. Cleared on the next accepted command or reset.
- `dut_rst_n` out 1: core reset.
- `gpio_to_dut` out 32: drives the core `gpio_in`. Bits [31:10] are always 0.
- `gpio_from_dut` in 32: the core `gpio_out`. Bits [31:10] are ignored.

## Operation
Expected byte count:
- `exp = (cmd_end > cmd_start) ? cmd_end − cmd_start : 0`.
- Computed as an 8-bit unsigned value at command accept and latched.

States and transitions:
- **IDLE**
  - `cmd_ready` = 1; `gpio_to_dut` = 0.
  - `cmd_valid` && !`abort` → accept: latch start/end/exp, clear `timeout_err`, go to DRST.
- **DRST**
  - `dut_rst_n` = 0 for `DUT_RST_CYCLES` cycles, then released; go to TX_REQ with byte index 0.
  - The FIFO is not flushed on accept; unread bytes from the previous command remain ahead of new data.
- **TX_REQ**
  - Drive `data` = start (index 0) or end (index 1), and `write` = 1.
  - Wait for synced core ack (`gpio_from_dut[8]`) = 1, then go to TX_REL.
- **TX_REL**
  - Drive `write` = 0; data is held.
  - Wait for synced ack = 0.
  - Index 0 → TX_REQ with index 1.
  - Index 1 → RX_WAIT if `exp` ≠ 0, else DONE.
- **RX_WAIT**
  - Wait for synced core strobe (`gpio_from_dut[9]`) = 1 and FIFO not full.
  - Then push `gpio_from_dut[7:0]` (sampled that cycle, unsynchronised; stable while the strobe is high) and go to RX_ACK.
- **RX_ACK**
  - Drive `read` = 1; wait for synced strobe = 0.
  - Then decrement the remaining count and go to RX_REL.
- **RX_REL**
  - Drive `read` = 0.
  - If remaining = 0 → DONE; else → RX_WAIT.
  - The core only re-strobes after `read` = 0.
- **DONE**: pulse `done`, go to IDLE.
- **ERR**
  - `gpio_to_dut` = 0, `dut_rst_n` = 0, `timeout_err` = 1.
  - Go to IDLE next cycle. No `done` pulse.

FIFO:
- Simultaneous push and pop is allowed when not empty; occupancy is unchanged.
- A push when full never happens (RX_WAIT stalls).

## Timing
Reset values (`rst_n` = 0 at a `clk` edge):
- State IDLE; FIFO empty; sync flops 0; `timeout_err` 0.
- `gpio_to_dut` 0; `dut_rst_n` 1; `done` 0; `busy` 0; `rx_valid` 0; `cmd_ready` 1 in the cycle after.

Output and latency rules:
- All outputs are registered or decoded from state only. No combinational path from `gpio_from_dut` to `gpio_to_dut`.
- Each core edge is seen `SYNC_STAGES` cycles late. Minimum per handshake half is `SYNC_STAGES`+1 cycles.

Timeout:
- The timeout counter resets on every state change.
- It counts in TX_REQ, TX_REL, RX_ACK, and in RX_WAIT only while the FIFO is not full (a full-FIFO stall never times out).
- Count = `TIMEOUT_CYCLES` → ERR.

Abort and reset:
- `abort` in any non-IDLE state → IDLE next cycle: FIFO flushed, `gpio_to_dut` 0, `dut_rst_n` 1, no `done`.
- `abort` and `cmd_valid` in IDLE in the same cycle → abort wins; nothing is accepted.
- `rst_n` mid-command behaves identically to abort, plus clearing `timeout_err`.

Throughput:
- `rx_ready` is honoured in the same cycle: the head advances at the next edge.

## Test plan
- **Normal range**: start=0x10, end=0x14 with `rx_ready`=1 → FIFO receives 0x10, 0x11, 0x12, 0x13 in order; exactly one `done`; `gpio_to_dut` = 0 afterwards.
- **Empty range**: start=0x20, end=0x20, then start=0x30, end=0x05 → no RX bytes; `done` after the second TX_REL; `rx_valid` stays 0.
- **Backpressure**: `FIFO_DEPTH`=4, start=0x00, end=0x0A, `rx_ready`=0 for 200 cycles → 4 entries held, no timeout. Then `rx_ready`=1 → 0x00..0x09 delivered and `done`.
- **Timeout**: core held in reset externally → TX_REQ waits `TIMEOUT_CYCLES` cycles, then `timeout_err`=1, `gpio_to_dut`=0, no `done`. The next command clears `timeout_err`.
- **Abort mid-RX**: start=0x00, end=0xFF, assert `abort` after the 3rd byte → IDLE next cycle, `rx_valid`=0, `busy`=0. A new command start=0x01, end=0x03 returns 0x01, 0x02.
- **Boundaries**: `abort` with `cmd_valid` in the same cycle in IDLE → not accepted; `rst_n` low mid-TX → all outputs at reset values on the following cycle.
